cnn_img_feeder: RTL and testbench
=================================

Name: cnn_img_feeder

Overview:
- Upstream stage of the CNN classifier core. Accepts one image as an 8-bit pixel byte stream using a valid/ready handshake and buffers it in an on-chip RAM.
- Once the frame is complete, it pulses start to the core and streams the pixels out as signed 32-bit words, paced by the core's din_ready.
- It then captures the core's one-hot class vector on done and presents it as a 4-bit index.

Parameters:
- IMG_PIXELS, 784, pixels per frame (28x28).
- PIX_W, 8, input pixel width.
- OFFSET, 128, value subtracted from each pixel before output.
- THRESH, 128, binarization threshold (only used with the optional feature).

Ports:
- clk  in  1  system clock.
- rstn  in  1  synchronous active-low reset.
- s_data  in  PIX_W  input pixel, unsigned.
- s_valid  in  1  s_data valid.
- s_ready  out  1  feeder can accept a pixel.
- cnn_start  out  1  one-cycle start pulse to the core.
- cnn_din  out  32  signed pixel word to the core.
- cnn_din_ready  in  1  core consumes cnn_din this cycle.
- cnn_done  in  1  core finished classification.
- cnn_classes  in  10  core one-hot class vector.
- result_class  out  4  decoded class index.
- result_valid  out  1  one-cycle pulse; result_class is valid in that cycle.
- busy  out  1  high in every state except LOAD.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset: synchronous; rstn low at any posedge clears everything, including mid-frame.
  - state=LOAD, wr_cnt=0, rd_cnt=0.
  - s_ready=1, cnn_start=0, cnn_din=0, result_class=0, result_valid=0, busy=0, proto_err=0.
  - Buffer contents are don't-care.
- LOAD:
  - s_ready=1. A pixel is written to buf[wr_cnt] when s_valid&s_ready.
  - A transfer with wr_cnt==IMG_PIXELS-1 moves to START. s_ready falls the next cycle, so exactly IMG_PIXELS pixels are accepted.
  - s_valid low stalls the frame indefinitely with no timeout.
- START:
  - One cycle. cnn_start=1.
  - buf[0] is prefetched so that cnn_din holds pixel 0 on entry to STREAM.
- STREAM:
  - cnn_din always holds pixel rd_cnt, as a registered output.
  - A transfer occurs on a cycle with cnn_din_ready=1. rd_cnt then increments and the next pixel appears the following cycle.
  - cnn_din_ready low holds cnn_din stable.
  - The transfer at rd_cnt==IMG_PIXELS-1 moves to WAIT.
  - cnn_din_ready in any other state is ignored.
- WAIT: on cnn_done=1, latch the decode of cnn_classes and pulse result_valid for one cycle. Next state is LOAD with wr_cnt=rd_cnt=0.
- Word conversion: cnn_din = sign-extend({1'b0, pixel} - OFFSET) to 32 bits. Range -128..127 at the defaults.
- Class decode: result_class = index of the lowest set bit of cnn_classes.
  - If cnn_classes==0, result_class=4'hF and proto_err is set.
  - If more than one bit is set, the lowest bit wins and proto_err is set.
- Protocol errors: cnn_done in LOAD, START or STREAM is ignored for state purposes and sets proto_err. proto_err clears only on reset.
- Timing: the start pulse precedes the first din transfer by at least one cycle. Best-case latency from last input pixel to first din transfer is 2 cycles.
- Simultaneous events: s_valid during STREAM or WAIT is not accepted (s_ready=0). The upstream source holds its data.

Optional Feature:
- Macro: CNN_FEEDER_BINARIZE_EN.
- Defined: cnn_din = +1 (32'sd1) if pixel >= THRESH, else -1 (32'hFFFFFFFF). This is for BNN first-layer binarized input; OFFSET is unused.
- Undefined: offset subtraction as described above; THRESH is unused.

Decomposition:
- Shared package cnn_pkg:
  - state encoding constants LOAD/START/STREAM/WAIT;
  - IMG_PIXELS and N_CLASSES=10 constants;
  - CLS_NONE=4'hF.
- One natural sub-module: cnn_onehot_dec (10-bit one-hot to 4-bit index, plus zero and multi-hot flags). It is combinational and shared with any other stage that reads class vectors.
- The buffer is an inferred single-clock simple dual-port RAM inside the top module.

Test Plan:
- Basic frame: feed pixels p[i]=i mod 256 with s_valid always high and din_ready always high. Expect:
  - one cnn_start pulse;
  - 784 transfers with cnn_din = (i mod 256) - 128, e.g. pixel 0 -> 0xFFFFFF80, pixel 200 -> 72;
  - cnn_classes=10'b0000100000 on done -> result_class=5 with a one-cycle result_valid.
- Backpressure: toggle din_ready randomly at 30% high. Expect cnn_din stable while ready is low, and the sequence identical with no drops or duplicates.
- Input gaps: s_valid low for 10 cycles at pixel 400. Expect wr_cnt to hold, and START only after the 784th accepted pixel.
- Error cases:
  - cnn_done during STREAM -> proto_err=1, state unchanged, streaming completes;
  - done with classes=0 -> result_class=F and proto_err=1.
- Reset mid-frame: assert rstn low during STREAM at rd_cnt=300. Expect all outputs at reset values next cycle and a fresh frame accepted correctly afterwards.
- Binarize build (macro defined): pixels 127 and 128 -> cnn_din -1 and +1 respectively.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants for the CNN classifier front-end stages.
package cnn_pkg;

   localparam int unsigned IMG_PIXELS = 784;
   localparam int unsigned N_CLASSES  = 10;
   localparam logic [3:0]  CLS_NONE   = 4'hF;

   localparam logic [1:0] LOAD   = 2'd0;
   localparam logic [1:0] START  = 2'd1;
   localparam logic [1:0] STREAM = 2'd2;
   localparam logic [1:0] WAIT   = 2'd3;

endpackage

// File: rtl/cnn_onehot_dec.sv
// One-hot class vector to index decoder; lowest set bit wins, with zero and multi-hot flags.
module cnn_onehot_dec
   import cnn_pkg::*;
(
   input  logic [N_CLASSES-1:0] i_classes,
   output logic [3:0]           o_idx,
   output logic                 o_zero,
   output logic                 o_multi
);

   // Scan downwards so the lowest set bit is the final assignment.
   always_comb begin
      o_idx = CLS_NONE;
      for (int unsigned i = N_CLASSES; i > 0; i--) begin
         if (i_classes[i-1]) o_idx = 4'(i - 1);
      end
   end

   assign o_zero  = (i_classes == '0);
   assign o_multi = |(i_classes & (i_classes - 1'b1));

endmodule

// File: rtl/cnn_img_feeder.sv
// Buffers one image frame, streams it to the CNN core and decodes the class result.
// Build option CNN_FEEDER_BINARIZE_EN: output +1/-1 by threshold instead of offset pixels.
module cnn_img_feeder #(
   parameter int unsigned IMG_PIXELS = cnn_pkg::IMG_PIXELS,
   parameter int unsigned PIX_W      = 8,
   parameter int unsigned OFFSET     = 128,
   parameter int unsigned THRESH     = 128
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [PIX_W-1:0] s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic             cnn_start,
   output logic [31:0]      cnn_din,
   input  logic             cnn_din_ready,
   input  logic             cnn_done,
   input  logic [9:0]       cnn_classes,
   output logic [3:0]       result_class,
   output logic             result_valid,
   output logic             busy,
   output logic             proto_err
);
   import cnn_pkg::*;

   localparam int unsigned CW = $clog2(IMG_PIXELS);
   localparam logic [CW-1:0] LAST_IDX = CW'(IMG_PIXELS - 1);

   logic [1:0]       r_state;
   logic [CW-1:0]    r_wr_cnt;
   logic [CW-1:0]    r_rd_cnt;
   logic [PIX_W-1:0] r_mem [IMG_PIXELS];
   logic [31:0]      r_din;
   logic [3:0]       r_result_class;
   logic             r_result_valid;
   logic             r_proto_err;

   logic             w_wr_en;
   logic             w_xfer;
   logic             w_last_rd;
   logic             w_rd_en;
   logic [CW-1:0]    w_rd_addr;
   logic [3:0]       w_cls_idx;
   logic             w_cls_zero;
   logic             w_cls_multi;
   logic [31:0]      w_unused_cfg;

   assign w_unused_cfg = 32'(OFFSET) ^ 32'(THRESH);

   function automatic logic [31:0] to_word(input logic [PIX_W-1:0] pix);
`ifdef CNN_FEEDER_BINARIZE_EN
      return (32'(pix) >= 32'(THRESH)) ? 32'd1 : '1;
`else
      return 32'(pix) - 32'(OFFSET);
`endif
   endfunction

   assign s_ready      = (r_state == LOAD);
   assign cnn_start    = (r_state == START);
   assign busy         = (r_state != LOAD);
   assign cnn_din      = r_din;
   assign result_class = r_result_class;
   assign result_valid = r_result_valid;
   assign proto_err    = r_proto_err;

   assign w_wr_en   = s_valid & s_ready;
   assign w_xfer    = (r_state == STREAM) & cnn_din_ready;
   assign w_last_rd = (r_rd_cnt == LAST_IDX);
   // START prefetches pixel 0; each non-final transfer fetches the following pixel.
   assign w_rd_en   = (r_state == START) | (w_xfer & ~w_last_rd);
   assign w_rd_addr = (r_state == START) ? '0 : r_rd_cnt + 1'b1;

   cnn_onehot_dec u_dec (
      .i_classes (cnn_classes),
      .o_idx     (w_cls_idx),
      .o_zero    (w_cls_zero),
      .o_multi   (w_cls_multi)
   );

   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_wr_cnt] <= s_data;
   end

   always_ff @(posedge clk) begin
      if (!rstn)        r_din <= '0;
      else if (w_rd_en) r_din <= to_word(r_mem[w_rd_addr]);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state        <= LOAD;
         r_wr_cnt       <= '0;
         r_rd_cnt       <= '0;
         r_result_class <= '0;
         r_result_valid <= 1'b0;
         r_proto_err    <= 1'b0;
      end else begin
         r_result_valid <= 1'b0;
         case (r_state)
            LOAD: begin
               if (w_wr_en) begin
                  if (r_wr_cnt == LAST_IDX) r_state  <= START;
                  else                      r_wr_cnt <= r_wr_cnt + 1'b1;
               end
            end
            START: begin
               r_rd_cnt <= '0;
               r_state  <= STREAM;
            end
            STREAM: begin
               if (w_xfer) begin
                  if (w_last_rd) r_state  <= WAIT;
                  else           r_rd_cnt <= r_rd_cnt + 1'b1;
               end
            end
            WAIT: begin
               if (cnn_done) begin
                  r_result_class <= w_cls_idx;
                  r_result_valid <= 1'b1;
                  if (w_cls_zero | w_cls_multi) r_proto_err <= 1'b1;
                  r_wr_cnt <= '0;
                  r_rd_cnt <= '0;
                  r_state  <= LOAD;
               end
            end
            default: r_state <= LOAD;
         endcase
         if (cnn_done && (r_state != WAIT)) r_proto_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cnn_img_feeder.sv
// Scoreboard bench for cnn_img_feeder: expected words queued on input acceptance, popped on din transfers.
module tb_cnn_img_feeder;

   localparam int N = 784;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [7:0]  s_data = '0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic        cnn_start;
   logic [31:0] cnn_din;
   logic        cnn_din_ready = 1'b0;
   logic        cnn_done = 1'b0;
   logic [9:0]  cnn_classes = '0;
   logic [3:0]  result_class;
   logic        result_valid;
   logic        busy;
   logic        proto_err;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] sb_q [$];
   logic        exp_perr = 1'b0;

   cnn_img_feeder dut (
      .clk           (clk),
      .rstn          (rstn),
      .s_data        (s_data),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .cnn_start     (cnn_start),
      .cnn_din       (cnn_din),
      .cnn_din_ready (cnn_din_ready),
      .cnn_done      (cnn_done),
      .cnn_classes   (cnn_classes),
      .result_class  (result_class),
      .result_valid  (result_valid),
      .busy          (busy),
      .proto_err     (proto_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_word(input logic [7:0] p);
`ifdef CNN_FEEDER_BINARIZE_EN
      return (p >= 8'd128) ? 32'd1 : 32'hFFFF_FFFF;
`else
      return 32'(int'(p) - 128);
`endif
   endfunction

   task automatic check_reset_outputs();
      chk("rst_s_ready", s_ready, 1);
      chk("rst_start", cnn_start, 0);
      chk("rst_din", cnn_din, 0);
      chk("rst_class", result_class, 0);
      chk("rst_valid", result_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_perr", proto_err, 0);
   endtask

   task automatic run_frame(input bit rand_pix, input int bp_pct, input int gap_at,
                            input int err_at, input int rst_at, input logic [9:0] cls,
                            input logic [3:0] exp_cls, input bit cls_err);
      int          i = 0;
      int          gap = 0;
      int          cyc = 0;
      int          xfer = 0;
      int          n_start = 0;
      bit          err_pend = 0;
      bit          err_done = 0;
      logic [7:0]  p;
      sb_q.delete();

      while (i < N && cyc < 4 * N) begin
         @(negedge clk);
         cyc++;
         chk("s_ready_load", s_ready, 1);
         n_start += int'(cnn_start);
         if (i == gap_at && gap < 10) begin
            s_valid = 1'b0;
            gap++;
         end else begin
            p = rand_pix ? 8'($urandom_range(0, 255)) : 8'(i);
            s_data  = p;
            s_valid = 1'b1;
            if (s_ready) begin
               sb_q.push_back(model_word(p));
               i++;
            end
         end
      end
      if (i < N) chk("load_timeout", i, N);

      @(negedge clk);
      s_data  = 8'hAA;
      s_valid = 1'b1;
      n_start += int'(cnn_start);
      chk("start_pulse", cnn_start, 1);
      chk("s_ready_start", s_ready, 0);
      chk("busy_start", busy, 1);
      cnn_din_ready = 1'($urandom_range(0, 1));

      cyc = 0;
      while (sb_q.size() > 0 && cyc < 20 * N) begin
         @(negedge clk);
         cyc++;
         n_start += int'(cnn_start);
         if (err_pend) begin
            chk("perr_stream", proto_err, 1);
            cnn_done = 1'b0;
            err_pend = 0;
         end
         chk("din", cnn_din, sb_q[0]);
         if (xfer == 10) chk("s_ready_stream", s_ready, 0);
         if (xfer == rst_at) begin
            rstn          = 1'b0;
            cnn_din_ready = 1'b0;
            s_valid       = 1'b0;
            @(negedge clk);
            check_reset_outputs();
            exp_perr = 1'b0;
            rstn     = 1'b1;
            sb_q.delete();
            return;
         end
         if (xfer == err_at && !err_done) begin
            cnn_done    = 1'b1;
            cnn_classes = 10'($urandom_range(0, 1023));
            err_pend    = 1;
            err_done    = 1;
            exp_perr    = 1'b1;
         end
         cnn_din_ready = ($urandom_range(0, 99) < bp_pct);
         if (cnn_din_ready) begin
            void'(sb_q.pop_front());
            xfer++;
         end
      end
      if (sb_q.size() > 0) chk("stream_timeout", sb_q.size(), 0);

      @(negedge clk);
      cnn_din_ready = 1'b0;
      s_valid       = 1'b0;
      n_start += int'(cnn_start);
      chk("busy_wait", busy, 1);
      chk("s_ready_wait", s_ready, 0);
      chk("valid_wait", result_valid, 0);
      @(negedge clk);
      cnn_done    = 1'b1;
      cnn_classes = cls;
      @(negedge clk);
      cnn_done = 1'b0;
      if (cls_err) exp_perr = 1'b1;
      chk("res_valid", result_valid, 1);
      chk("res_class", result_class, exp_cls);
      chk("perr_end", proto_err, exp_perr);
      chk("busy_idle", busy, 0);
      chk("s_ready_idle", s_ready, 1);
      @(negedge clk);
      chk("res_valid_pulse", result_valid, 0);
      chk("res_class_hold", result_class, exp_cls);
      chk("start_count", n_start, 1);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_reset_outputs();
      rstn = 1'b1;

      run_frame(0, 100, -1,  -1,  -1, 10'b0000100000, 4'd5, 0);
      run_frame(0,  30, 400, -1,  -1, 10'b1000000000, 4'd9, 0);
      run_frame(1,  50, -1,  100, -1, 10'b0000000000, 4'hF, 1);
      run_frame(0,  30, -1,  -1, 300, 10'b0000000001, 4'd0, 0);
      run_frame(1,  30, 123, -1,  -1, 10'b0010001000, 4'd3, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
